// File: rtl/load_store_unit.sv
// load_store_unit: forms base+offset addresses and sequences one load/store at a time to the 16-bit data memory.
// Optional build macro LSU_BOUNDS_CHECK_EN: faults accesses at or beyond MEM_DEPTH without touching memory.
`timescale 1ns/1ps

module load_store_unit_chk #(
  parameter int MEM_DEPTH = 33
) (
  input logic clock,
  input logic reset,
  input logic accept,
  input logic in_range,
  input logic req_ready,
  input logic resp_valid,
  input logic resp_err,
  input logic mem_memread,
  input logic mem_memwrite
);

  logic in_range_accept_r;

  // Remembers that the previous edge accepted an in-range request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_range_accept_r <= 1'b0;
    end else begin
      in_range_accept_r <= accept && in_range && (MEM_DEPTH > 0);
    end
  end

  // Protocol invariants on the memory and response sides.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(mem_memread && mem_memwrite));
      assert (!((mem_memread || mem_memwrite) && (req_ready || resp_valid)));
      assert (!(in_range_accept_r && resp_err));
    end
  end

endmodule

module load_store_unit #(
  parameter int MEM_DEPTH = 33,
  parameter int ADDR_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_write,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [15:0]       mem_read
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              we_r;
  logic [ADDR_W-1:0] eff_addr_s;
  logic              in_range_s;
  logic              fault_s;
  logic              accept_s;
  logic              issue_s;

  // Sum wraps at ADDR_W bits; the carry is intentionally dropped.
  assign eff_addr_s = req_base + req_offset;
  assign in_range_s = (32'(eff_addr_s) < 32'(MEM_DEPTH));
`ifdef LSU_BOUNDS_CHECK_EN
  assign fault_s    = !in_range_s;
`else
  assign fault_s    = 1'b0;
`endif
  assign accept_s   = (state_r == IDLE) && req_ready && req_valid;
  assign issue_s    = accept_s && !fault_s;

  // Next-state selection for the single-outstanding-request sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (fault_s) begin
            state_s = RESP;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_s = RESP;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        state_s = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus every registered output; memory strobes are armed on the edge entering ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 16'h0000;
      resp_err     <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_write    <= 16'h0000;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready    <= (state_s == IDLE);
      resp_valid   <= (state_s == RESP);
      mem_memread  <= issue_s && !req_we;
      mem_memwrite <= issue_s && req_we;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r       <= req_we;
            resp_rdata <= 16'h0000;
            resp_err   <= fault_s;
            if (!fault_s) begin
              mem_addr <= eff_addr_s;
              if (req_we) begin
                mem_write <= req_wdata;
              end
            end
          end
        end
        CAPTURE: begin
          resp_rdata <= mem_read;
        end
        default: begin
        end
      endcase
    end
  end

  load_store_unit_chk #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_chk (
    .clock        (clock),
    .reset        (reset),
    .accept       (accept_s),
    .in_range     (in_range_s),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite)
  );

endmodule
